// File: rtl/led_effect_gen.sv
// led_effect_gen
// Effect engine feeding the WS2812B serializer with a time-varying 24-bit GRB word.
// Control logic selects a mode and a base colour over a valid/ready handshake.
// The engine then produces one of five effects: off, solid, blink, breathe or rainbow.
// Effect state only advances on a prescaled tick.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   cfg_valid     in   config request, taken when cfg_valid & cfg_ready at a clk edge
//   cfg_ready     out  high when a config can be accepted
//   cfg_mode      in   0 OFF, 1 SOLID, 2 BLINK, 3 BREATHE, 4 RAINBOW, 5-7 OFF
//   cfg_rgb       in   {R,G,B} base colour (unused in OFF/RAINBOW)
//   led_color_out out  {G,R,B} colour word, two-stage pipelined from effect state
//   tick_out      out  one-cycle pulse on every effect tick
module led_effect_gen #(
    parameter int unsigned TICK_DIV           = 27000,
    parameter int unsigned BLINK_TICKS        = 500,
    parameter int unsigned BREATHE_STEP_TICKS = 4,
    parameter int unsigned RAINBOW_STEP_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_mode,
    input  logic [23:0] cfg_rgb,
    output logic [23:0] led_color_out,
    output logic        tick_out
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam int unsigned MAX_AB  = (BLINK_TICKS > BREATHE_STEP_TICKS) ?
                                      BLINK_TICKS : BREATHE_STEP_TICKS;
    localparam int unsigned MAX_STEP = (MAX_AB > RAINBOW_STEP_TICKS) ?
                                       MAX_AB : RAINBOW_STEP_TICKS;
    localparam int unsigned STEP_W  = $clog2(MAX_STEP + 1);

    typedef enum logic [2:0] {
        ModeOff     = 3'd0,
        ModeSolid   = 3'd1,
        ModeBlink   = 3'd2,
        ModeBreathe = 3'd3,
        ModeRainbow = 3'd4
    } mode_e;

    mode_e               mode_q;
    logic [23:0]         rgb_q;
    logic                cfg_ready_q;
    logic [PRESC_W-1:0]  presc_q;
    logic [STEP_W-1:0]   step_cnt_q;
    logic                blink_on_q;
    logic [7:0]          bright_q;
    logic                dir_up_q;
    logic [7:0]          hue_q;
    logic [23:0]         mul_q;
    logic [23:0]         led_q;

    logic                tick;
    logic                accept;
    logic [STEP_W-1:0]   step_last;

    assign tick          = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign accept        = cfg_valid & cfg_ready_q;
    assign cfg_ready     = cfg_ready_q;
    assign tick_out      = tick;
    assign led_color_out = led_q;

    // Number of ticks per effect step, minus one, for the active mode.
    always_comb begin
        step_last = '0;
        case (mode_q)
            ModeBlink:   step_last = STEP_W'(BLINK_TICKS - 1);
            ModeBreathe: step_last = STEP_W'(BREATHE_STEP_TICKS - 1);
            ModeRainbow: step_last = STEP_W'(RAINBOW_STEP_TICKS - 1);
            default:     step_last = '0;
        endcase
    end

    // Control and effect state. A config accept restarts everything, including on a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= ModeOff;
            rgb_q       <= '0;
            cfg_ready_q <= 1'b1;
            presc_q     <= '0;
            step_cnt_q  <= '0;
            blink_on_q  <= 1'b1;
            bright_q    <= '0;
            dir_up_q    <= 1'b1;
            hue_q       <= '0;
        end else begin
            // Ready drops for exactly the cycle after an accept.
            cfg_ready_q <= ~accept;
            if (accept) begin
                mode_q     <= (cfg_mode > 3'd4) ? ModeOff : mode_e'(cfg_mode);
                rgb_q      <= cfg_rgb;
                presc_q    <= '0;
                step_cnt_q <= '0;
                blink_on_q <= 1'b1;
                bright_q   <= '0;
                dir_up_q   <= 1'b1;
                hue_q      <= '0;
            end else begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (step_cnt_q == step_last) begin
                        step_cnt_q <= '0;
                        case (mode_q)
                            ModeBlink: blink_on_q <= ~blink_on_q;
                            ModeBreathe: begin
                                // Triangle wave; each endpoint occupies a single step.
                                if (dir_up_q) begin
                                    if (bright_q == 8'd255) begin
                                        dir_up_q <= 1'b0;
                                        bright_q <= 8'd254;
                                    end else begin
                                        bright_q <= bright_q + 8'd1;
                                    end
                                end else begin
                                    if (bright_q == 8'd0) begin
                                        dir_up_q <= 1'b1;
                                        bright_q <= 8'd1;
                                    end else begin
                                        bright_q <= bright_q - 8'd1;
                                    end
                                end
                            end
                            ModeRainbow: hue_q <= hue_q + 8'd1;
                            default: ;
                        endcase
                    end else begin
                        step_cnt_q <= step_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    // Hue wheel: three 85-step segments, each ramping 3 LSB per hue step.
    logic [7:0] hue_k;
    logic [7:0] ramp;
    logic [7:0] rain_r, rain_g, rain_b;

    always_comb begin
        rain_r = 8'd0;
        rain_g = 8'd0;
        rain_b = 8'd0;
        if (hue_q < 8'd85) begin
            hue_k  = hue_q;
        end else if (hue_q < 8'd170) begin
            hue_k  = hue_q - 8'd85;
        end else begin
            hue_k  = hue_q - 8'd170;
        end
        ramp = hue_k + hue_k + hue_k;
        if (hue_q < 8'd85) begin
            rain_r = 8'd255 - ramp;
            rain_g = ramp;
        end else if (hue_q < 8'd170) begin
            rain_g = 8'd255 - ramp;
            rain_b = ramp;
        end else begin
            rain_r = ramp;
            rain_b = 8'd255 - ramp;
        end
    end

    // Base colour, brightness and enable for the current effect state.
    logic [23:0] base_rgb;
    logic [7:0]  bright;
    logic        enable;
    logic [8:0]  scale;

    always_comb begin
        base_rgb = rgb_q;
        bright   = 8'd255;
        enable   = 1'b0;
        case (mode_q)
            ModeSolid:   enable = 1'b1;
            ModeBlink:   enable = blink_on_q;
            ModeBreathe: begin
                enable = 1'b1;
                bright = bright_q;
            end
            ModeRainbow: begin
                enable   = 1'b1;
                base_rgb = {rain_r, rain_g, rain_b};
            end
            default:     enable = 1'b0;
        endcase
        scale = {1'b0, bright} + 9'd1;
    end

    // (c * (b + 1)) >> 8: exact pass-through at b = 255, zero at b = 0.
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] s);
        return 8'(({8'd0, c} * {7'd0, s}) >> 8);
    endfunction

    // Stage 1 registers the scaled channels (already in GRB order), stage 2 the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_q <= '0;
            led_q <= '0;
        end else begin
            mul_q <= enable ? {scale_ch(base_rgb[15:8], scale),
                               scale_ch(base_rgb[23:16], scale),
                               scale_ch(base_rgb[7:0], scale)} : 24'd0;
            led_q <= mul_q;
        end
    end

endmodule

// File: tb/tb_led_effect_gen.sv
module tb_led_effect_gen;

    localparam int unsigned TICK_DIV           = 4;
    localparam int unsigned BLINK_TICKS        = 2;
    localparam int unsigned BREATHE_STEP_TICKS = 1;
    localparam int unsigned RAINBOW_STEP_TICKS = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_mode;
    logic [23:0] cfg_rgb;
    logic [23:0] led_color_out;
    logic        tick_out;

    led_effect_gen #(
        .TICK_DIV          (TICK_DIV),
        .BLINK_TICKS       (BLINK_TICKS),
        .BREATHE_STEP_TICKS(BREATHE_STEP_TICKS),
        .RAINBOW_STEP_TICKS(RAINBOW_STEP_TICKS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_mode     (cfg_mode),
        .cfg_rgb      (cfg_rgb),
        .led_color_out(led_color_out),
        .tick_out     (tick_out)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: effect as a function of ticks since the last restart.
    int          m_mode;
    logic [23:0] m_rgb;
    int          m_since;
    logic        m_ready;
    logic [23:0] pipe0, pipe1, m_out;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %06h, expected %06h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] scl(input int c, input int b);
        return 8'((c * (b + 1)) / 256);
    endfunction

    function automatic logic [23:0] effect_colour(input int mode, input logic [23:0] rgb,
                                                  input int ticks);
        int n, b, h, k, r, g, bl;
        r  = int'(rgb[23:16]);
        g  = int'(rgb[15:8]);
        bl = int'(rgb[7:0]);
        case (mode)
            1: return {rgb[15:8], rgb[23:16], rgb[7:0]};
            2: return (((ticks / BLINK_TICKS) % 2) == 0) ?
                      {rgb[15:8], rgb[23:16], rgb[7:0]} : 24'd0;
            3: begin
                n = (ticks / BREATHE_STEP_TICKS) % 510;
                b = (n <= 255) ? n : 510 - n;
                return {scl(g, b), scl(r, b), scl(bl, b)};
            end
            4: begin
                h = (ticks / RAINBOW_STEP_TICKS) % 256;
                if (h < 85) begin
                    r = 255 - 3 * h; g = 3 * h; bl = 0;
                end else if (h < 170) begin
                    k = h - 85; r = 0; g = 255 - 3 * k; bl = 3 * k;
                end else begin
                    k = h - 170; r = 3 * k; g = 0; bl = 255 - 3 * k;
                end
                return {8'(g), 8'(r), 8'(bl)};
            end
            default: return 24'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_rgb   = 24'd0;
        m_since = 0;
        m_ready = 1'b1;
        pipe0   = 24'd0;
        pipe1   = 24'd0;
        m_out   = 24'd0;
    endtask

    // One clock: update the model at the rising edge, compare on the falling edge.
    task automatic cycle();
        logic acc;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc     = cfg_valid && m_ready;
            m_ready = !acc;
            if (acc) begin
                m_mode  = (cfg_mode > 3'd4) ? 0 : int'(cfg_mode);
                m_rgb   = cfg_rgb;
                m_since = 0;
            end else begin
                m_since++;
            end
            m_out = pipe1;
            pipe1 = pipe0;
            pipe0 = effect_colour(m_mode, m_rgb, m_since / TICK_DIV);
        end
        @(negedge clk);
        check("led", led_color_out, m_out);
        check("tick", 24'(tick_out), 24'((m_since % TICK_DIV) == TICK_DIV - 1));
        check("ready", 24'(cfg_ready), 24'(m_ready));
    endtask

    task automatic send(input logic [2:0] mode, input logic [23:0] rgb);
        for (int i = 0; i < 4 && !m_ready; i++) cycle();
        cfg_valid = 1'b1;
        cfg_mode  = mode;
        cfg_rgb   = rgb;
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_led", led_color_out, 24'd0);
        check("rst_ready", 24'(cfg_ready), 24'd1);
        check("rst_tick", 24'(tick_out), 24'd0);
        model_reset();
        cfg_valid = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_mode  = 3'd0;
        cfg_rgb   = 24'd0;
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        repeat (5) cycle();

        // SOLID: ready low for one cycle, colour at the second edge after accept.
        send(3'd1, 24'h123456);
        check("solid_ready_low", 24'(cfg_ready), 24'd0);
        cycle();
        check("solid_not_yet", led_color_out, 24'd0);
        check("solid_ready_back", 24'(cfg_ready), 24'd1);
        cycle();
        check("solid_out", led_color_out, 24'h341256);
        repeat (10) cycle();

        // BLINK red.
        send(3'd2, 24'hFF0000);
        repeat (40) cycle();

        // BREATHE white through two full triangle periods.
        send(3'd3, 24'hFFFFFF);
        repeat (2 * 510 * TICK_DIV + 12) cycle();

        // RAINBOW around the full wheel and past the wrap.
        send(3'd4, 24'h000000);
        repeat (260 * TICK_DIV) cycle();

        // Accept on a tick cycle while breathing at b=10.
        send(3'd3, 24'hFFFFFF);
        repeat (10 * TICK_DIV + TICK_DIV - 1) cycle();
        check("t6_on_tick", 24'(tick_out), 24'd1);
        send(3'd3, 24'hFFFFFF);
        check("t6_tick_n", 24'(tick_out), 24'd0);
        cycle();
        check("t6_old_out", led_color_out, 24'h0A0A0A);
        cycle();
        check("t6_restart", led_color_out, 24'h000000);
        check("t6_tick_n2", 24'(tick_out), 24'd0);
        cycle();
        check("t6_tick_n3", 24'(tick_out), 24'd1);
        repeat (20) cycle();

        // Reset mid-run in RAINBOW.
        send(3'd4, 24'h000000);
        repeat (37) cycle();
        do_reset();
        repeat (8) cycle();

        // Randomized configs, including reserved modes, held valid and rare resets.
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = ($urandom_range(0, 29) == 0);
            cfg_mode  = 3'($urandom_range(0, 7));
            cfg_rgb   = 24'($urandom);
            if ($urandom_range(0, 999) == 0) do_reset();
            else cycle();
        end
        cfg_valid = 1'b0;
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
